// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetch queue.
// Issues word fetches over a request/grant port. Responses come back in
// request order and land in a small PC-tagged FIFO, which the core drains
// through a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch. Responses still in flight from before the redirect are counted in
// 'discard' and dropped when they arrive.
// Optional build macro IPQ_BYPASS_EN: when the FIFO is empty, a live
// response is presented to the core in the same cycle it arrives.
module instr_prefetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 64
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic [AW-1:0]              startpc,
   input  logic                       redirect,
   input  logic [AW-1:0]              redirect_pc,
   output logic                       mem_req,
   output logic [AW-1:0]              mem_addr,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   input  logic [31:0]                mem_rdata,
   output logic                       inst_valid,
   output logic [31:0]                inst_data,
   output logic [AW-1:0]              inst_pc,
   input  logic                       inst_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [AW-1:0] ALIGN = {{(AW-2){1'b1}}, 2'b00};

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [AW-1:0] pcs_q  [DEPTH];
   logic [AW-1:0] pcs_d  [DEPTH];

   logic [CW+1:0] credit_used;
   logic          grant;
   logic          rsp_live;
   logic          rsp_drop;
   logic          rsp_take;
   logic          byp;
   logic          push;
   logic          pop;
   logic          rvalid_dec;

   // A live response either retires a stale request or fills the next slot;
   // a response with nothing outstanding and nothing to discard is ignored.
   assign rsp_live = mem_rvalid & ~redirect;
   assign rsp_drop = rsp_live & (disc_q != '0);
   assign rsp_take = rsp_live & (disc_q == '0) & (out_q != '0);

`ifdef IPQ_BYPASS_EN
   assign byp = rsp_take & (count_q == '0);
`else
   assign byp = 1'b0;
`endif

   // Handshake decode: every buffered, outstanding or discarded word holds a credit
   always_comb begin
      credit_used = (CW+2)'(count_q) + (CW+2)'(out_q) + (CW+2)'(disc_q);
      mem_req     = ~reset & ~redirect & (credit_used < (CW+2)'(DEPTH));
      grant       = mem_req & mem_gnt;
      push        = rsp_take & ~(byp & inst_ready);
      pop         = (count_q != '0) & inst_ready & ~redirect;
      rvalid_dec  = mem_rvalid & ((disc_q != '0) | (out_q != '0));
      mem_addr    = fetch_pc_q;
      inst_valid  = ~reset & ((count_q != '0) | byp);
      inst_data   = byp ? mem_rdata : data_q[head_q];
      inst_pc     = byp ? resp_pc_q : pcs_q[head_q];
      occupancy   = reset ? '0 : count_q;
   end

   // Next-state for PCs, counters and pointers; a redirect flushes and wins over a pop
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      out_d      = out_q;
      disc_d     = disc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc & ALIGN;
         resp_pc_d  = redirect_pc & ALIGN;
         count_d    = '0;
         out_d      = '0;
         head_d     = tail_q;
         disc_d     = disc_q + out_q - CW'(rvalid_dec);
      end else begin
         if (grant)    fetch_pc_d = fetch_pc_q + AW'(4);
         if (rsp_take) resp_pc_d  = resp_pc_q + AW'(4);
         if (rsp_drop) disc_d     = disc_q - CW'(1);
         if (push)     tail_d     = tail_q + PW'(1);
         if (pop)      head_d     = head_q + PW'(1);
         out_d   = out_q + CW'(grant) - CW'(rsp_take);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Storage write at the tail
   always_comb begin
      data_d = data_q;
      pcs_d  = pcs_q;
      if (push) begin
         data_d[tail_q] = mem_rdata;
         pcs_d[tail_q]  = resp_pc_q;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge CLK) begin
      if (reset) begin
         fetch_pc_q <= startpc & ALIGN;
         resp_pc_q  <= startpc & ALIGN;
         count_q    <= '0;
         out_q      <= '0;
         disc_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // FIFO payload; contents are only meaningful under count_q, so no reset
   always_ff @(posedge CLK) begin
      data_q <= data_d;
      pcs_q  <= pcs_d;
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: a memory model with 2-cycle response
// latency and a PC/data scoreboard tagged with a flush epoch.
module tb_instr_prefetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 64;
   localparam int CW    = $clog2(DEPTH+1);
   localparam int BIG   = 1000000;
`ifdef IPQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] startpc = 64'h1000;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          inst_valid;
   logic [31:0]   inst_data;
   logic [AW-1:0] inst_pc;
   logic          inst_ready = 1'b0;
   logic [CW-1:0] occupancy;

   instr_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK(CLK), .reset(reset), .startpc(startpc), .redirect(redirect),
      .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .occupancy(occupancy)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic [AW-1:0] addr; int due; int ep; } req_t;
   typedef struct { logic [AW-1:0] pc; logic [31:0] data; } exp_t;

   req_t mq[$];
   exp_t sb[$];
   req_t h;
   exp_t e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int epoch = 0;
   int rsp_allow = BIG;
   bit gnt_en = 1'b1;
   int n_grants = 0;
   int n_consumed = 0;
   bit got_first = 1'b0;
   logic [AW-1:0] first_pc = '0;
   logic [AW-1:0] exp_fetch = '0;

   function automatic logic [31:0] mdata(input logic [AW-1:0] a);
      return (a[33:2] * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   // Memory drives at negedge+1, model samples at negedge+4 (just before posedge)
   always begin
      @(negedge CLK);
      #1;
      mem_gnt = gnt_en;
      if (mq.size() > 0 && mq[0].due <= cyc && rsp_allow > 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mdata(mq[0].addr);
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
      #3;
      if (reset) begin
         checks++;
         if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_in_reset: mem_req=%b required 0", mem_req);
         end
         mq.delete();
         sb.delete();
         epoch++;
         exp_fetch = startpc & ~64'h3;
         got_first = 1'b0;
      end else begin
         if (mem_rvalid) begin
            h = mq.pop_front();
            if (rsp_allow > 0) rsp_allow--;
            if (!redirect && h.ep == epoch) sb.push_back('{h.addr, mdata(h.addr)});
         end
         if (inst_valid && inst_ready && !redirect) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_inst: pc=%h data=%h required none", inst_pc, inst_data);
            end else begin
               e = sb.pop_front();
               if (inst_pc !== e.pc || inst_data !== e.data) begin
                  errors++;
                  $display("FAIL inst_stream: pc=%h data=%h required pc=%h data=%h",
                           inst_pc, inst_data, e.pc, e.data);
               end
            end
            n_consumed++;
            if (!got_first) begin
               got_first = 1'b1;
               first_pc  = inst_pc;
            end
         end
         if (mem_req && mem_gnt) begin
            checks++;
            if (mem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL fetch_addr: mem_addr=%h required %h", mem_addr, exp_fetch);
            end
            mq.push_back('{mem_addr, cyc + 2, epoch});
            exp_fetch = exp_fetch + 64'd4;
            n_grants++;
         end
         if (redirect) begin
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL req_in_redirect: mem_req=%b required 0", mem_req);
            end
            sb.delete();
            epoch++;
            exp_fetch = redirect_pc & ~64'h3;
            got_first = 1'b0;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic do_reset(input logic [AW-1:0] pc);
      tick();
      reset = 1'b1;
      startpc = pc;
      rsp_allow = BIG;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_consumed(input int n, output bit ok);
      int c0;
      c0 = n_consumed;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (n_consumed >= c0 + n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      tick();
      reset = 1'b1;
      startpc = 64'h1000;
      inst_ready = 1'b1;
      repeat (2) tick();
      #3;
      checks++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0 || occupancy !== '0 || mem_addr !== 64'h1000) begin
         errors++;
         $display("FAIL reset_outputs: req=%b valid=%b occ=%0d addr=%h required 0 0 0 1000",
                  mem_req, inst_valid, occupancy, mem_addr);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_stream();
      bit ok;
      inst_ready = 1'b1;
      wait_consumed(12, ok);
      checks++;
      if (!ok || !got_first || first_pc !== 64'h1000) begin
         errors++;
         $display("FAIL stream_first: ok=%b pc=%h required 1000", ok, first_pc);
      end
   endtask

   task automatic test_latency();
      bit found;
      do_reset(64'h1000);
      inst_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #3;
         if (mem_rvalid === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!found || inst_valid !== BYP || occupancy !== '0) begin
         errors++;
         $display("FAIL latency_first: found=%b valid=%b occ=%0d required valid=%b occ=0",
                  found, inst_valid, occupancy, BYP);
      end
      tick();
      #3;
      checks++;
      if (inst_valid !== 1'b1 || occupancy !== (BYP ? CW'(0) : CW'(1))) begin
         errors++;
         $display("FAIL latency_next: valid=%b occ=%0d required 1 %0d", inst_valid, occupancy, BYP ? 0 : 1);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int g0;
      bit ok;
      do_reset(64'h1000);
      inst_ready = 1'b0;
      g0 = n_grants;
      repeat (10) tick();
      #3;
      checks++;
      if (n_grants - g0 != DEPTH || occupancy !== CW'(DEPTH) || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL backpressure: grants=%0d occ=%0d req=%b required 4 4 0",
                  n_grants - g0, occupancy, mem_req);
      end
      tick();
      inst_ready = 1'b1;
      wait_consumed(8, ok);
      checks++;
      if (!ok || first_pc !== 64'h1000) begin
         errors++;
         $display("FAIL drain_first: ok=%b pc=%h required 1000", ok, first_pc);
      end
   endtask

   task automatic test_redirect();
      bit ok;
      bit hit;
      do_reset(64'h1000);
      inst_ready = 1'b0;
      rsp_allow = 0;
      repeat (6) tick();
      rsp_allow = 2;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #3;
         if (occupancy === CW'(2)) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      tick();
      redirect = 1'b1;
      redirect_pc = 64'h2002;
      #3;
      checks++;
      if (!hit || mq.size() != 2 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL redirect_setup: hit=%b inflight=%0d req=%b required 1 2 0", hit, mq.size(), mem_req);
      end
      tick();
      redirect = 1'b0;
      rsp_allow = BIG;
      #3;
      checks++;
      if (occupancy !== '0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_flush: occ=%0d valid=%b required 0 0", occupancy, inst_valid);
      end
      inst_ready = 1'b1;
      wait_consumed(6, ok);
      checks++;
      if (!ok || first_pc !== 64'h2000) begin
         errors++;
         $display("FAIL redirect_first: ok=%b pc=%h required 2000", ok, first_pc);
      end
   endtask

   task automatic test_redirect_collision();
      bit ok;
      rsp_allow = 0;
      repeat (4) tick();
      inst_ready = 1'b0;
      rsp_allow = 2;
      repeat (4) tick();
      inst_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 64'h3000;
      rsp_allow = 1;
      #3;
      checks++;
      if (mem_rvalid !== 1'b1 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL collision_setup: rvalid=%b valid=%b required 1 1", mem_rvalid, inst_valid);
      end
      tick();
      redirect = 1'b0;
      rsp_allow = BIG;
      #3;
      checks++;
      if (occupancy !== '0) begin
         errors++;
         $display("FAIL collision_flush: occ=%0d required 0", occupancy);
      end
      wait_consumed(8, ok);
      checks++;
      if (!ok || first_pc !== 64'h3000) begin
         errors++;
         $display("FAIL collision_first: ok=%b pc=%h required 3000", ok, first_pc);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      inst_ready = 1'b1;
      tick();
      redirect = 1'b1;
      redirect_pc = 64'h4000;
      tick();
      redirect_pc = 64'h5007;
      tick();
      redirect = 1'b0;
      wait_consumed(10, ok);
      checks++;
      if (!ok || first_pc !== 64'h5004) begin
         errors++;
         $display("FAIL b2b_first: ok=%b pc=%h required 5004", ok, first_pc);
      end
   endtask

   task automatic test_reset_midburst();
      bit ok;
      rsp_allow = 0;
      repeat (5) tick();
      #3;
      checks++;
      if (mq.size() < 3) begin
         errors++;
         $display("FAIL midburst_setup: inflight=%0d required >=3", mq.size());
      end
      tick();
      reset = 1'b1;
      startpc = 64'h1000;
      #3;
      checks++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0 || occupancy !== '0) begin
         errors++;
         $display("FAIL midburst_reset: req=%b valid=%b occ=%0d required 0 0 0", mem_req, inst_valid, occupancy);
      end
      tick();
      rsp_allow = BIG;
      tick();
      reset = 1'b0;
      #3;
      checks++;
      if (occupancy !== '0 || inst_valid !== 1'b0 || mem_addr !== 64'h1000 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL midburst_restart: occ=%0d valid=%b addr=%h req=%b required 0 0 1000 1",
                  occupancy, inst_valid, mem_addr, mem_req);
      end
      wait_consumed(6, ok);
      checks++;
      if (!ok || first_pc !== 64'h1000) begin
         errors++;
         $display("FAIL midburst_first: ok=%b pc=%h required 1000", ok, first_pc);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset(64'hFFFF_FFFF_FFFF_FFF9);
      inst_ready = 1'b1;
      wait_consumed(8, ok);
      checks++;
      if (!ok || first_pc !== 64'hFFFF_FFFF_FFFF_FFF8) begin
         errors++;
         $display("FAIL wrap_first: ok=%b pc=%h required fffffffffffffff8", ok, first_pc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_latency();
      test_backpressure();
      test_redirect();
      test_redirect_collision();
      test_back_to_back();
      test_reset_midburst();
      test_wrap();
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
